// File: rtl/game_pkg.sv
// Shared formation geometry, collision FSM states
// and the alive-mask index helper.
package game_pkg;

  localparam int FORM_ROWS    = 5;
  localparam int FORM_COLS    = 11;
  localparam int FORM_CELL_W  = 48;
  localparam int FORM_CELL_H  = 40;
  localparam int FORM_ALIEN_W = 32;
  localparam int FORM_ALIEN_H = 24;

  typedef enum logic [2:0] {
    IDLE,
    OFFS,
    DIVX,
    DIVY,
    CHECK,
    HIT
  } state_t;

  function automatic int mask_index(
    input int row,
    input int col,
    input int cols = FORM_COLS
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/cell_locate.sv
// Serial subtract-divide: splits a non-negative offset
// into cell index and in-cell remainder, one step per cycle.
module cell_locate #(
  parameter int VW    = 17,
  parameter int PITCH = 48,
  parameter int QW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [VW-1:0] value,
  output logic          done,
  output logic [QW-1:0] quot,
  output logic [VW-1:0] rem
);

  localparam logic [VW-1:0] P = VW'(PITCH);

  logic run;

  // load on start, subtract while rem >= pitch, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      done <= 1'b0;
      quot <= '0;
      rem  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= value;
        quot <= '0;
        run  <= 1'b1;
      end else if (run) begin
        if (rem >= P) begin
          rem  <= rem - P;
          quot <= quot + QW'(1);
        end else begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bullet_collision.sv
// Per-frame bullet vs formation hit test; owns the
// alive mask, the score and the bullet retire reset.
module bullet_collision
  import game_pkg::*;
#(
  parameter int SCREEN_CORDW = 16,
  parameter int ALIEN_ROWS   = FORM_ROWS,
  parameter int ALIEN_COLS   = FORM_COLS,
  parameter int CELL_W       = FORM_CELL_W,
  parameter int CELL_H       = FORM_CELL_H,
  parameter int ALIEN_W      = FORM_ALIEN_W,
  parameter int ALIEN_H      = FORM_ALIEN_H,
  parameter int BULLET_W     = 40,
  parameter int SCORE_W      = 16,
  parameter int POINTS       = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame,
  input  logic                           wave_reset,
  input  logic                           bullet_moving,
  input  logic signed [SCREEN_CORDW-1:0] bullet_x,
  input  logic signed [SCREEN_CORDW-1:0] bullet_y,
  input  logic signed [SCREEN_CORDW-1:0] grid_x,
  input  logic signed [SCREEN_CORDW-1:0] grid_y,
  output logic [ALIEN_ROWS*ALIEN_COLS-1:0] alive_mask,
  output logic                           hit,
  output logic [$clog2(ALIEN_ROWS)-1:0]  hit_row,
  output logic [$clog2(ALIEN_COLS)-1:0]  hit_col,
  output logic [SCORE_W-1:0]             score,
  output logic                           all_dead,
  output logic                           bullet_rst_n,
  output logic                           busy
);

  localparam int N  = ALIEN_ROWS * ALIEN_COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ALIEN_ROWS);
  localparam int CW = $clog2(ALIEN_COLS);
  localparam int PW = SCREEN_CORDW + 1;
  localparam int SW = SCREEN_CORDW;

  localparam logic [PW-1:0] HALF_BW = PW'(BULLET_W / 2);
  localparam logic [PW-1:0] SPAN_X  = PW'(ALIEN_COLS * CELL_W);
  localparam logic [PW-1:0] SPAN_Y  = PW'(ALIEN_ROWS * CELL_H);
  localparam logic [PW-1:0] AW      = PW'(ALIEN_W);
  localparam logic [PW-1:0] AH      = PW'(ALIEN_H);

  state_t state;

  logic [SW-1:0] bx_q, by_q, gx_q, gy_q;
  logic [PW-1:0] dx, dy, rem_x, rem_y;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] idx;
  logic          in_range, kill;
  logic          x_start, x_done;
  logic          y_start, y_done;
  logic          retire_q;
  logic [SCORE_W:0] sum;

  // probe point in formation space, one bit wider
  always_comb begin
    dx = {bx_q[SW-1], bx_q} + HALF_BW
       - {gx_q[SW-1], gx_q};
    dy = {by_q[SW-1], by_q}
       - {gy_q[SW-1], gy_q};
    in_range = !dx[PW-1] && !dy[PW-1]
            && dx < SPAN_X && dy < SPAN_Y;
    idx  = IW'(mask_index(int'(row), int'(col), ALIEN_COLS));
    kill = rem_x < AW && rem_y < AH && alive_mask[idx];
    sum  = {1'b0, score} + (SCORE_W+1)'(POINTS);
  end

  assign x_start = state == OFFS && in_range;
  assign y_start = state == DIVX && x_done;

  cell_locate #(.VW(PW), .PITCH(CELL_W), .QW(CW)) u_locx (
    .clk   (clk),
    .rst   (rst),
    .start (x_start),
    .value (dx),
    .done  (x_done),
    .quot  (col),
    .rem   (rem_x)
  );

  cell_locate #(.VW(PW), .PITCH(CELL_H), .QW(RW)) u_locy (
    .clk   (clk),
    .rst   (rst),
    .start (y_start),
    .value (dy),
    .done  (y_done),
    .quot  (row),
    .rem   (rem_y)
  );

  // latch positions when an evaluation starts
  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q <= '0;
      by_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
    end else if (state == IDLE && frame && bullet_moving) begin
      bx_q <= bullet_x;
      by_q <= bullet_y;
      gx_q <= grid_x;
      gy_q <= grid_y;
    end
  end

  // scan sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (frame && bullet_moving) state <= OFFS;
        OFFS:    state <= in_range ? DIVX : IDLE;
        DIVX:    if (x_done) state <= DIVY;
        DIVY:    if (y_done) state <= CHECK;
        CHECK:   state <= kill ? HIT : IDLE;
        HIT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // mask, score, last-kill position and bullet retire
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_mask <= '1;
      score      <= '0;
      hit_row    <= '0;
      hit_col    <= '0;
      retire_q   <= 1'b0;
    end else begin
      if (wave_reset) begin
        alive_mask <= '1;
      end else if (state == HIT) begin
        alive_mask[idx] <= 1'b0;
        score   <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        hit_row <= row;
        hit_col <= col;
      end
      if (state == HIT) retire_q <= 1'b1;
      else if (frame)   retire_q <= 1'b0;
    end
  end

  assign hit          = state == HIT && !wave_reset;
  assign bullet_rst_n = !(retire_q || state == HIT);
  assign busy         = state != IDLE;
  assign all_dead     = ~|alive_mask;

endmodule

// File: tb/tb_bullet_collision.sv
// Randomized and directed checks of bullet_collision
// against a divide/modulo formation model.
module tb_bullet_collision;

  localparam int W   = 16;
  localparam int R   = 5;
  localparam int C   = 11;
  localparam int CW  = 48;
  localparam int CH  = 40;
  localparam int AW  = 32;
  localparam int AH  = 24;
  localparam int BW  = 40;
  localparam int PTS = 10;
  localparam int N   = R * C;
  localparam int SMAX = 65535;

  logic clk = 1'b0;
  logic rst, frame, wave_reset, bullet_moving;
  logic signed [W-1:0] bullet_x, bullet_y, grid_x, grid_y;
  logic [N-1:0] alive_mask;
  logic         hit;
  logic [2:0]   hit_row;
  logic [3:0]   hit_col;
  logic [15:0]  score;
  logic         all_dead, bullet_rst_n, busy;

  always #5 clk = ~clk;

  bullet_collision dut (
    .clk           (clk),
    .rst           (rst),
    .frame         (frame),
    .wave_reset    (wave_reset),
    .bullet_moving (bullet_moving),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .grid_x        (grid_x),
    .grid_y        (grid_y),
    .alive_mask    (alive_mask),
    .hit           (hit),
    .hit_row       (hit_row),
    .hit_col       (hit_col),
    .score         (score),
    .all_dead      (all_dead),
    .bullet_rst_n  (bullet_rst_n),
    .busy          (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  bit m_alive [N];
  int m_score;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic int sat(input int s);
    return (s > SMAX) ? SMAX : s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    m_score = 0;
  endtask

  task automatic set_pos(input int bx, input int by,
                         input int gx, input int gy);
    bullet_x = W'(bx);
    bullet_y = W'(by);
    grid_x   = W'(gx);
    grid_y   = W'(gy);
  endtask

  // one frame-triggered evaluation; dup_at > 0 re-strobes frame
  task automatic shoot(input int bx, input int by,
                       input int gx, input int gy,
                       input int dup_at);
    int dx, dy, col, row, cyc, nhit, hit_cyc;
    int got_row, got_col;
    bit in_rng, exp_hit, rst_n_seen;
    dx = bx + BW / 2 - gx;
    dy = by - gy;
    in_rng = dx >= 0 && dy >= 0 && dx < C * CW && dy < R * CH;
    col = in_rng ? dx / CW : 0;
    row = in_rng ? dy / CH : 0;
    exp_hit = in_rng && (dx % CW) < AW && (dy % CH) < AH
           && m_alive[row * C + col];
    set_pos(bx, by, gx, gy);
    bullet_moving = 1'b1;
    frame = 1'b1;
    cyc = 1;
    nhit = 0;
    hit_cyc = 0;
    got_row = 0;
    got_col = 0;
    rst_n_seen = 1'b1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      frame = (cyc == dup_at);
      if (hit) begin
        nhit++;
        hit_cyc = cyc;
      end
      if (!busy) begin
        got_row = int'(hit_row);
        got_col = int'(hit_col);
        rst_n_seen = bullet_rst_n;
        break;
      end
    end
    frame = 1'b0;
    check("scan_done", 64'(busy), 64'(0));
    check("hit_count", 64'(nhit), 64'(exp_hit));
    if (exp_hit) begin
      check("hit_cycle", 64'(hit_cyc), 64'(8 + col + row));
      check("hit_row", 64'(got_row), 64'(row));
      check("hit_col", 64'(got_col), 64'(col));
      check("retire_low", 64'(rst_n_seen), 64'(0));
      m_alive[row * C + col] = 1'b0;
      m_score = sat(m_score + PTS);
    end
    check("mask", 64'(alive_mask), 64'(m_vec()));
    check("score", 64'(score), 64'(m_score));
    check("all_dead", 64'(all_dead), 64'(m_vec() == '0));
  endtask

  // frame with no bullet in flight releases the retire reset
  task automatic release_frame(input bit was_low);
    bullet_moving = 1'b0;
    frame = 1'b1;
    check("retire_hold", 64'(bullet_rst_n), 64'(!was_low));
    @(negedge clk);
    frame = 1'b0;
    check("retire_free", 64'(bullet_rst_n), 64'(1));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic do_wave();
    wave_reset = 1'b1;
    @(negedge clk);
    wave_reset = 1'b0;
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    check("wave_mask", 64'(alive_mask), 64'(m_vec()));
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    rst = 1'b1;
    frame = 1'b0;
    wave_reset = 1'b0;
    bullet_moving = 1'b0;
    set_pos(0, 0, 0, 0);
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mask", 64'(alive_mask), 64'(m_vec()));
    check("rst_score", 64'(score), 64'(0));
    check("rst_hit", 64'(hit), 64'(0));
    check("rst_row", 64'(hit_row), 64'(0));
    check("rst_col", 64'(hit_col), 64'(0));
    check("rst_retire", 64'(bullet_rst_n), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dead", 64'(all_dead), 64'(0));

    shoot(96, 60, 100, 50, 0);
    release_frame(1'b1);
    shoot(132, 60, 100, 50, 0);
    shoot(120, 60, 100, 50, 0);
    shoot(96, 60, 100, 50, 0);
    do_wave();
    shoot(112, 60, 100, 50, 0);
    shoot(127, 60, 100, 50, 0);
    shoot(608, 60, 100, 50, 0);
    shoot(591, 60, 100, 50, 0);
    shoot(591, 250, 100, 50, 0);
    shoot(90, 49, 100, 50, 0);
    shoot(79, 60, 100, 50, 0);

    for (int k = 0; k < 200; k++) begin
      int gx, gy, bx, by, dup;
      gx = int'($urandom_range(0, 200));
      gy = int'($urandom_range(0, 120));
      bx = gx - 40 + int'($urandom_range(0, 580));
      by = gy - 10 + int'($urandom_range(0, 220));
      dup = int'($urandom_range(0, 6));
      shoot(bx, by, gx, gy, (dup >= 4) ? dup : 0);
      if (($urandom & 31) == 0) do_wave();
    end

    do_rst();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        shoot(100 + c * CW - BW / 2 + 5, 50 + r * CH + 3,
              100, 50, 0);
    check("kill_all_dead", 64'(all_dead), 64'(1));
    check("kill_all_score", 64'(score), 64'(550));

    // back-to-back kills of cell 0, wave restored on each frame
    set_pos(85, 53, 100, 50);
    bullet_moving = 1'b1;
    for (int k = 0; k < 6500; k++) begin
      frame = 1'b1;
      wave_reset = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      wave_reset = 1'b0;
      repeat (7) @(negedge clk);
      m_score = sat(m_score + PTS);
    end
    for (int i = 0; i < N; i++) m_alive[i] = (i != 0);
    check("sat_score", 64'(score), 64'(m_score));
    check("sat_max", 64'(score), 64'(16'hFFFF));
    check("sat_mask", 64'(alive_mask), 64'(m_vec()));

    // reset while the x divider is running
    set_pos(565, 213, 100, 50);
    bullet_moving = 1'b1;
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    @(negedge clk);
    check("divx_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_retire", 64'(bullet_rst_n), 64'(1));
    check("mid_mask", 64'(alive_mask), 64'(m_vec()));
    check("mid_score", 64'(score), 64'(0));
    check("mid_hit", 64'(hit), 64'(0));

    shoot(565, 213, 100, 50, 5);
    shoot(565, 213, 100, 50, 12);
    release_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
